// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC controller: FSM state encoding, BTB entry layout, PC step.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_state_e;

    // Tag is held right-aligned in a full word so the entry layout does not depend on depth.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update (built only with FETCH_BTB_EN).
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc_i,
    output logic        hit_o,
    output logic [31:0] target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t             mem_q [ENTRIES];
    btb_entry_t             rd_entry;
    logic       [IDX_W-1:0] rd_idx;
    logic       [IDX_W-1:0] wr_idx;
    logic                   unused_low;

    assign rd_idx     = lookup_pc_i[IDX_W+1:2];
    assign wr_idx     = upd_pc_i[IDX_W+1:2];
    assign unused_low = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // Reads the registered array, so a same-cycle update to this index is not yet visible.
    assign rd_entry = mem_q[rd_idx];
    assign hit_o    = rd_entry.valid && (rd_entry.tag == (lookup_pc_i >> (IDX_W + 2)));
    assign target_o = rd_entry.target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (upd_valid_i) begin
            mem_q[wr_idx] <= '{valid:  1'b1,
                               tag:    upd_pc_i >> (IDX_W + 2),
                               target: {upd_target_i[31:2], 2'b00}};
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: advance on accept, hold under backpressure, redirect with one flush bubble.
// Define FETCH_BTB_EN to add a direct-mapped BTB that supplies next_pc on a hit.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        fetch_ready,
    input  logic        btb_upd_valid,
    input  logic [31:0] btb_upd_pc,
    input  logic [31:0] btb_upd_target,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic        flush_out,
    output logic [2:0]  state_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  seq_pc;
    logic [31:0]  next_pc;
    logic         accept;

    assign seq_pc = pc_q + PC_INCR;

`ifdef FETCH_BTB_EN
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        unused_ign;

    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .lookup_pc_i  (pc_q),
        .hit_o        (btb_hit),
        .target_o     (btb_target),
        .upd_valid_i  (btb_upd_valid),
        .upd_pc_i     (btb_upd_pc),
        .upd_target_i (btb_upd_target)
    );

    assign next_pc    = btb_hit ? btb_target : seq_pc;
    assign unused_ign = ^redirect_pc[1:0];
`else
    logic unused_ign;

    assign next_pc    = seq_pc;
    assign unused_ign = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, redirect_pc[1:0],
                          (BTB_ENTRIES == 0)};
`endif

    assign pc_valid  = (state_q == RUN) || (state_q == STALL);
    assign accept    = pc_valid && fetch_ready;
    assign flush_out = redirect_valid;
    assign pc_out    = pc_q;
    assign state_out = state_q;

    // Priority: redirect, then halt (which still honours a same-cycle accept), then flow control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = halt_req ? HALT : FLUSH;
        end else if (halt_req) begin
            if (accept) begin
                pc_d = next_pc;
            end
            state_d = HALT;
        end else begin
            unique case (state_q)
                BOOT, FLUSH, HALT: state_d = RUN;
                RUN, STALL: begin
                    if (fetch_ready) begin
                        pc_d    = next_pc;
                        state_d = RUN;
                    end else begin
                        state_d = STALL;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: vector table plus hand sequences for reset, BOOT redirect, halt and BTB.
module tb_fetch_pc_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          W        = 37;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_ready;
    logic        btb_upd_valid;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        flush_out;
    logic [2:0]  state_out;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         rv;
        logic [31:0]  rpc;
        logic         halt;
        logic         rdy;
        logic [31:0]  e_pc;
        logic         e_v;
        logic         e_f;
        fetch_state_e e_st;
    } vec_t;

    vec_t vecs[30];

    fetch_pc_ctrl #(
        .RESET_PC    (RESET_PC),
        .BTB_ENTRIES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .fetch_ready    (fetch_ready),
        .btb_upd_valid  (btb_upd_valid),
        .btb_upd_pc     (btb_upd_pc),
        .btb_upd_target (btb_upd_target),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .flush_out      (flush_out),
        .state_out      (state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pack_exp(input logic [31:0] e_pc, input logic e_v,
                                              input logic e_f, input fetch_state_e e_st);
        return {e_st, e_f, e_v, e_pc};
    endfunction

    task automatic sb_check(input string nm);
        logic [W-1:0] act;
        logic [W-1:0] exp;
        act = {state_out, flush_out, pc_valid, pc_out};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got state=%0d flush=%b valid=%b pc=%h",
                     nm, act[36:34], act[33], act[32], act[31:0]);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                bad++;
                $display("FAIL %s: got state=%0d flush=%b valid=%b pc=%h, want state=%0d flush=%b valid=%b pc=%h",
                         nm, act[36:34], act[33], act[32], act[31:0],
                         exp[36:34], exp[33], exp[32], exp[31:0]);
            end
        end
    endtask

    // Entered at posedge+1: drive, record expectation, sample at negedge, return at next posedge+1.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic halt, input logic rdy,
                        input logic [31:0] e_pc, input logic e_v, input logic e_f,
                        input fetch_state_e e_st, input string nm);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = halt;
        fetch_ready    = rdy;
        exp_q.push_back(pack_exp(e_pc, e_v, e_f, e_st));
        @(negedge clk);
        sb_check(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        fetch_ready    = 1'b1;
        btb_upd_valid  = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        fetch_ready    = 1'b1;
        btb_upd_valid  = 1'b0;
        btb_upd_pc     = 32'h0;
        btb_upd_target = 32'h0;

        //            rv    rpc           halt  rdy   e_pc          e_v   e_f   e_st
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, BOOT};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, RUN};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 1'b0, RUN};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b0, RUN};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        1'b1, 1'b0, RUN};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 1'b0, RUN};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 1'b0, STALL};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 1'b0, STALL};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b1, 1'b0, STALL};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       1'b1, 1'b0, RUN};
        vecs[10] = '{1'b1, 32'h203,      1'b0, 1'b1, 32'h18,       1'b1, 1'b1, RUN};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0, 1'b0, FLUSH};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b1, 1'b0, RUN};
        vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h204,      1'b1, 1'b0, RUN};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h208,      1'b1, 1'b0, RUN};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h20C,      1'b0, 1'b0, HALT};
        vecs[16] = '{1'b1, 32'h300,      1'b1, 1'b1, 32'h20C,      1'b0, 1'b1, HALT};
        vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      1'b0, 1'b0, HALT};
        vecs[18] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      1'b0, 1'b0, HALT};
        vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h300,      1'b1, 1'b0, RUN};
        vecs[20] = '{1'b1, 32'h310,      1'b0, 1'b0, 32'h300,      1'b1, 1'b1, STALL};
        vecs[21] = '{1'b1, 32'h322,      1'b0, 1'b1, 32'h310,      1'b0, 1'b1, FLUSH};
        vecs[22] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h320,      1'b0, 1'b0, FLUSH};
        vecs[23] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h320,      1'b1, 1'b0, RUN};
        vecs[24] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h324,     1'b1, 1'b1, RUN};
        vecs[25] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, FLUSH};
        vecs[26] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, RUN};
        vecs[27] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, RUN};
        vecs[28] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h4,        1'b1, 1'b0, RUN};
        vecs[29] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h4,        1'b1, 1'b0, STALL};

        #3;
        exp_q.push_back(pack_exp(RESET_PC, 1'b0, 1'b0, BOOT));
        sb_check("reset_hold");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step(vecs[i].rv, vecs[i].rpc, vecs[i].halt, vecs[i].rdy,
                 vecs[i].e_pc, vecs[i].e_v, vecs[i].e_f, vecs[i].e_st,
                 $sformatf("vec%0d", i));
        end

        // Asynchronous reset while stalled must take effect before any clock edge.
        fetch_ready = 1'b0;
        reset       = 1'b1;
        #1;
        exp_q.push_back(pack_exp(RESET_PC, 1'b0, 1'b0, BOOT));
        sb_check("async_reset_mid_stall");
        @(posedge clk);
        #1;
        reset = 1'b0;

        step(1'b1, 32'h501, 1'b0, 1'b1, RESET_PC, 1'b0, 1'b1, BOOT,  "boot_redirect");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h500,  1'b0, 1'b0, FLUSH, "boot_redirect_bubble");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h500,  1'b1, 1'b0, RUN,   "boot_redirect_pc");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h504,  1'b1, 1'b0, RUN,   "boot_redirect_next");

        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1, RESET_PC, 1'b0, 1'b0, BOOT, "boot_halt");
        step(1'b0, 32'h0, 1'b1, 1'b1, RESET_PC, 1'b0, 1'b0, HALT, "halt_hold");
        step(1'b0, 32'h0, 1'b0, 1'b1, RESET_PC, 1'b0, 1'b0, HALT, "halt_release");
        step(1'b0, 32'h0, 1'b0, 1'b1, RESET_PC, 1'b1, 1'b0, RUN,  "halt_resume");

`ifdef FETCH_BTB_EN
        do_reset();
        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h100;
        btb_upd_target = 32'h400;
        step(1'b0, 32'h0, 1'b0, 1'b1, RESET_PC, 1'b0, 1'b0, BOOT, "btb_update");
        btb_upd_valid  = 1'b0;
        step(1'b1, 32'h100, 1'b0, 1'b1, RESET_PC, 1'b1, 1'b1, RUN,   "btb_redir");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h100,  1'b0, 1'b0, FLUSH, "btb_bubble");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h100,  1'b1, 1'b0, RUN,   "btb_fetch_branch");
        step(1'b1, 32'h140, 1'b0, 1'b1, 32'h400,  1'b1, 1'b1, RUN,   "btb_hit_target");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h140,  1'b0, 1'b0, FLUSH, "btb_alias_bubble");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h140,  1'b1, 1'b0, RUN,   "btb_alias_fetch");
        step(1'b0, 32'h0,   1'b0, 1'b1, 32'h144,  1'b1, 1'b0, RUN,   "btb_alias_miss");
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
